// File: rtl/sm_pkg.sv
// Shared constants for the SM instruction path: widths, the NOP/HALT encodings
// and the sequencer state encoding.
package sm_pkg;

    localparam int INSTRUCTION_WIDTH = 15;
    localparam int PC_WIDTH          = 8;
    localparam int COUNT_WIDTH       = 16;

    localparam logic [INSTRUCTION_WIDTH-1:0] NOP  = 15'h42C0;
    localparam logic [INSTRUCTION_WIDTH-1:0] HALT = 15'h43C0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_RUN   = 2'd2,
        ST_HOLD  = 2'd3
    } sm_state_t;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sm_sequencer.sv
// Feeds SM one instruction per cycle from a registered-output instruction RAM,
// yielding the core bus to the host and resuming at the first unissued word.
module sm_sequencer
    import sm_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [PC_WIDTH-1:0]          start_pc,
    input  logic                         abort,
    input  logic                         host_req,
    output logic                         host_gnt,
    output logic [PC_WIDTH-1:0]          imem_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_q,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         busy,
    output logic                         done,
    output logic [PC_WIDTH-1:0]          pc,
    output logic [COUNT_WIDTH-1:0]       issued
);

    sm_state_t                    r_state;
    sm_state_t                    w_state_nxt;
    logic [INSTRUCTION_WIDTH-1:0] r_instr;
    logic [INSTRUCTION_WIDTH-1:0] w_instr_nxt;
    logic                         r_done;
    logic                         w_done_nxt;
    logic                         r_gnt;
    logic                         w_gnt_nxt;
    logic [PC_WIDTH-1:0]          r_pc;
    logic [PC_WIDTH-1:0]          w_pc_nxt;
    logic [PC_WIDTH-1:0]          r_addr;
    logic [PC_WIDTH-1:0]          w_addr_nxt;
    logic [COUNT_WIDTH-1:0]       r_issued;
    logic [COUNT_WIDTH-1:0]       w_issued_nxt;
    logic                         w_start_ok;
    logic                         w_is_halt;

    assign w_start_ok = start && !r_gnt;
    assign w_is_halt  = (imem_q == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok) w_state_nxt = ST_FETCH;
            ST_FETCH: w_state_nxt = abort ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (abort)          w_state_nxt = ST_IDLE;
                else if (host_req)  w_state_nxt = ST_HOLD;
                else if (w_is_halt) w_state_nxt = ST_IDLE;
            end
            ST_HOLD: begin
                if (abort)          w_state_nxt = ST_IDLE;
                else if (!host_req) w_state_nxt = ST_FETCH;
            end
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // imem_addr always runs one word ahead of pc while in RUN, and is parked
    // on pc whenever the next state is FETCH so the refetch hits the right word.
    always_comb begin
        w_instr_nxt  = NOP;
        w_done_nxt   = 1'b0;
        w_gnt_nxt    = r_gnt;
        w_pc_nxt     = r_pc;
        w_addr_nxt   = r_addr;
        w_issued_nxt = r_issued;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt = host_req;
                if (w_start_ok) begin
                    w_pc_nxt     = start_pc;
                    w_addr_nxt   = start_pc;
                    w_issued_nxt = '0;
                end
            end
            ST_FETCH: begin
                if (!abort) w_addr_nxt = r_pc + PC_WIDTH'(1);
            end
            ST_RUN: begin
                if (abort) begin
                    w_gnt_nxt = 1'b0;
                end else if (host_req) begin
                    w_gnt_nxt  = 1'b1;
                    w_addr_nxt = r_pc;
                end else if (w_is_halt) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_instr_nxt  = imem_q;
                    w_issued_nxt = sat_inc(r_issued);
                    w_pc_nxt     = r_pc + PC_WIDTH'(1);
                    w_addr_nxt   = r_pc + PC_WIDTH'(2);
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    w_gnt_nxt = 1'b0;
                end else if (!host_req) begin
                    w_gnt_nxt  = 1'b0;
                    w_addr_nxt = r_pc;
                end
            end
            default: w_gnt_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr  <= NOP;
            r_done   <= 1'b0;
            r_gnt    <= 1'b0;
            r_pc     <= '0;
            r_addr   <= '0;
            r_issued <= '0;
        end else begin
            r_instr  <= w_instr_nxt;
            r_done   <= w_done_nxt;
            r_gnt    <= w_gnt_nxt;
            r_pc     <= w_pc_nxt;
            r_addr   <= w_addr_nxt;
            r_issued <= w_issued_nxt;
        end
    end

    assign instruction = r_instr;
    assign done        = r_done;
    assign host_gnt    = r_gnt;
    assign pc          = r_pc;
    assign imem_addr   = r_addr;
    assign issued      = r_issued;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sm_sequencer.sv
// Directed bench for sm_sequencer with a behavioural registered-output RAM.
module tb_sm_sequencer;
    import sm_pkg::*;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         start;
    logic [PC_WIDTH-1:0]          start_pc;
    logic                         abort;
    logic                         host_req;
    logic                         host_gnt;
    logic [PC_WIDTH-1:0]          imem_addr;
    logic [INSTRUCTION_WIDTH-1:0] imem_q;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
    logic                         busy;
    logic                         done;
    logic [PC_WIDTH-1:0]          pc;
    logic [COUNT_WIDTH-1:0]       issued;

    logic [INSTRUCTION_WIDTH-1:0] mem [0:255];

    int n_vec = 0;
    int n_bad = 0;

    sm_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
        .abort(abort), .host_req(host_req), .host_gnt(host_gnt),
        .imem_addr(imem_addr), .imem_q(imem_q), .instruction(instruction),
        .busy(busy), .done(done), .pc(pc), .issued(issued)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_q <= mem[imem_addr];

    typedef struct {
        logic        start;
        logic [7:0]  spc;
        logic        abort;
        logic        hreq;
        logic [14:0] instr;
        logic        gnt;
        logic        busy;
        logic        done;
        logic [7:0]  pc;
        logic [15:0] iss;
    } vec_t;

    vec_t vt [23];

    function automatic vec_t mk(input logic s, input logic [7:0] spc, input logic ab,
                                input logic hr, input logic [14:0] ins, input logic g,
                                input logic b, input logic d, input logic [7:0] p,
                                input logic [15:0] is);
        vec_t r;
        r.start = s; r.spc = spc; r.abort = ab; r.hreq = hr;
        r.instr = ins; r.gnt = g; r.busy = b; r.done = d; r.pc = p; r.iss = is;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [7:0] spc, input logic ab, input logic hr);
        start = s; start_pc = spc; abort = ab; host_req = hr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return 64'({instruction, host_gnt, busy, done, pc, issued});
    endfunction

    function automatic logic [63:0] pack_exp(input vec_t v);
        return 64'({v.instr, v.gnt, v.busy, v.done, v.pc, v.iss});
    endfunction

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 15'h0;
        mem[8'h10] = 15'h0280; mem[8'h11] = 15'h0090; mem[8'h12] = 15'h0AA4; mem[8'h13] = HALT;
        mem[8'h20] = 15'h0101; mem[8'h21] = 15'h0202; mem[8'h22] = 15'h0303;
        mem[8'h23] = 15'h0404; mem[8'h24] = 15'h0505; mem[8'h25] = 15'h0606; mem[8'h26] = HALT;
        mem[8'h40] = 15'h0111; mem[8'h41] = HALT;
        mem[8'hFE] = 15'h0F01; mem[8'hFF] = 15'h0F02; mem[8'h00] = 15'h0F03; mem[8'h01] = HALT;

        // basic 3-instruction program at 0x10
        vt[0]  = mk(1, 8'h10, 0, 0, NOP,      0, 1, 0, 8'h10, 0);
        vt[1]  = mk(0, 8'h00, 0, 0, NOP,      0, 1, 0, 8'h10, 0);
        vt[2]  = mk(0, 8'h00, 0, 0, 15'h0280, 0, 1, 0, 8'h11, 1);
        vt[3]  = mk(0, 8'h00, 0, 0, 15'h0090, 0, 1, 0, 8'h12, 2);
        vt[4]  = mk(0, 8'h00, 0, 0, 15'h0AA4, 0, 1, 0, 8'h13, 3);
        vt[5]  = mk(0, 8'h00, 0, 0, NOP,      0, 0, 1, 8'h13, 3);
        vt[6]  = mk(0, 8'h00, 0, 0, NOP,      0, 0, 0, 8'h13, 3);
        // 6-word program with a 4-cycle host hold over the second word
        vt[7]  = mk(1, 8'h20, 0, 0, NOP,      0, 1, 0, 8'h20, 0);
        vt[8]  = mk(0, 8'h00, 0, 0, NOP,      0, 1, 0, 8'h20, 0);
        vt[9]  = mk(0, 8'h00, 0, 0, 15'h0101, 0, 1, 0, 8'h21, 1);
        vt[10] = mk(0, 8'h00, 0, 1, NOP,      1, 1, 0, 8'h21, 1);
        vt[11] = mk(0, 8'h00, 0, 1, NOP,      1, 1, 0, 8'h21, 1);
        vt[12] = mk(0, 8'h00, 0, 1, NOP,      1, 1, 0, 8'h21, 1);
        vt[13] = mk(0, 8'h00, 0, 1, NOP,      1, 1, 0, 8'h21, 1);
        vt[14] = mk(0, 8'h00, 0, 0, NOP,      0, 1, 0, 8'h21, 1);
        vt[15] = mk(0, 8'h00, 0, 0, NOP,      0, 1, 0, 8'h21, 1);
        vt[16] = mk(0, 8'h00, 0, 0, 15'h0202, 0, 1, 0, 8'h22, 2);
        vt[17] = mk(0, 8'h00, 0, 0, 15'h0303, 0, 1, 0, 8'h23, 3);
        vt[18] = mk(0, 8'h00, 0, 0, 15'h0404, 0, 1, 0, 8'h24, 4);
        vt[19] = mk(0, 8'h00, 0, 0, 15'h0505, 0, 1, 0, 8'h25, 5);
        vt[20] = mk(0, 8'h00, 0, 0, 15'h0606, 0, 1, 0, 8'h26, 6);
        vt[21] = mk(0, 8'h00, 0, 0, NOP,      0, 0, 1, 8'h26, 6);
        vt[22] = mk(0, 8'h00, 0, 0, NOP,      0, 0, 0, 8'h26, 6);

        rst_n = 1'b0;
        drive(0, 8'h00, 0, 0);
        #12;
        chk("reset_outs", outs(), 64'({NOP, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000}));
        chk("reset_addr", 64'(imem_addr), 64'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 23; i++) begin
            drive(vt[i].start, vt[i].spc, vt[i].abort, vt[i].hreq);
            tick();
            chk($sformatf("vec%0d", i), outs(), pack_exp(vt[i]));
        end

        // host_req on the same edge HALT sits on imem_q
        drive(1, 8'h40, 0, 0); tick();
        drive(0, 8'h00, 0, 0); tick(); tick();
        chk("hh_first", 64'(instruction), 64'h0111);
        drive(0, 8'h00, 0, 1); tick();
        chk("hh_hold", outs(), 64'({NOP, 1'b1, 1'b1, 1'b0, 8'h41, 16'd1}));
        drive(0, 8'h00, 0, 0); tick();
        chk("hh_release", outs(), 64'({NOP, 1'b0, 1'b1, 1'b0, 8'h41, 16'd1}));
        tick();
        chk("hh_refetch", outs(), 64'({NOP, 1'b0, 1'b1, 1'b0, 8'h41, 16'd1}));
        tick();
        chk("hh_done", outs(), 64'({NOP, 1'b0, 1'b0, 1'b1, 8'h41, 16'd1}));

        // abort together with host_req mid-RUN, then a clean restart
        drive(1, 8'h10, 0, 0); tick();
        drive(0, 8'h00, 0, 0); tick(); tick();
        chk("ab_first", 64'(instruction), 64'h0280);
        drive(0, 8'h00, 1, 1); tick();
        chk("ab_abort", outs(), 64'({NOP, 1'b0, 1'b0, 1'b0, 8'h11, 16'd1}));
        drive(0, 8'h00, 0, 0); tick();
        chk("ab_nodone", 64'({done, busy, host_gnt}), 64'h0);
        drive(1, 8'h10, 0, 0); tick();
        drive(0, 8'h00, 0, 0); tick(); tick();
        chk("ab_r0", 64'(instruction), 64'h0280);
        tick(); chk("ab_r1", 64'(instruction), 64'h0090);
        tick(); chk("ab_r2", 64'(instruction), 64'h0AA4);
        tick(); chk("ab_rdone", outs(), 64'({NOP, 1'b0, 1'b0, 1'b1, 8'h13, 16'd3}));

        // pc wrap from 0xFE through 0x00
        drive(1, 8'hFE, 0, 0); tick();
        drive(0, 8'h00, 0, 0); tick(); tick();
        chk("wr_0", 64'({instruction, pc}), 64'({15'h0F01, 8'hFF}));
        tick(); chk("wr_1", 64'({instruction, pc}), 64'({15'h0F02, 8'h00}));
        tick(); chk("wr_2", 64'({instruction, pc}), 64'({15'h0F03, 8'h01}));
        tick(); chk("wr_done", outs(), 64'({NOP, 1'b0, 1'b0, 1'b1, 8'h01, 16'd3}));

        // asynchronous reset mid-RUN
        drive(1, 8'h20, 0, 0); tick();
        drive(0, 8'h00, 0, 0); tick(); tick(); tick();
        chk("rr_running", 64'(instruction), 64'h0202);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_outs", outs(), 64'({NOP, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0}));
        chk("rr_addr", 64'(imem_addr), 64'h0);
        #2 rst_n = 1'b1;

        // asynchronous reset mid-HOLD, then start ignored while host owns the bus
        drive(1, 8'h20, 0, 0); tick();
        drive(0, 8'h00, 0, 0); tick(); tick();
        drive(0, 8'h00, 0, 1); tick();
        chk("rh_hold", 64'(host_gnt), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rh_outs", outs(), 64'({NOP, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0}));
        #2 rst_n = 1'b1;
        tick();
        chk("ig_gnt", 64'({host_gnt, busy}), 64'b10);
        drive(1, 8'h10, 0, 1); tick();
        chk("ig_start0", 64'({host_gnt, busy, pc}), 64'({1'b1, 1'b0, 8'h00}));
        tick();
        chk("ig_start1", 64'({host_gnt, busy, pc}), 64'({1'b1, 1'b0, 8'h00}));
        drive(0, 8'h00, 0, 0); tick();
        chk("ig_release", 64'({host_gnt, busy}), 64'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sm_sequencer.md
# sm_sequencer

Instruction sequencer for the SM. Fetches 15-bit instructions from a synchronous instruction memory, issues one per cycle on the SM `instruction` input, and injects NOP whenever no program is running. Shares the memory_manager core bus with the host: host requests pre-empt the running program, and the program resumes at the first unissued instruction. Sits between the host control registers, the instruction RAM and SM.

## Interface
- INSTRUCTION_WIDTH, 15, SM instruction width
- PC_WIDTH, 8, instruction-memory address width
- COUNT_WIDTH, 16, issued-instruction counter width
- NOP, 15'h42C0 (1_0000_1011_00_00_00), SM no-op encoding
- HALT, 15'h43C0 (1_0000_1111_00_00_00), end-of-program marker, never issued

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin program at start_pc; sampled in IDLE only
- start_pc  in  PC_WIDTH  first instruction address
- abort  in  1  stop immediately, no done pulse
- host_req  in  1  host wants the core bus (memory_manager traffic)
- host_gnt  out  1  host owns the bus; SM is fed NOP
- imem_addr  out  PC_WIDTH  instruction RAM read address
- imem_q  in  INSTRUCTION_WIDTH  RAM data, 1-cycle read latency
- instruction  out  INSTRUCTION_WIDTH  registered instruction to SM
- busy  out  1  high in FETCH, RUN, HOLD
- done  out  1  one-cycle pulse on HALT retirement
- pc  out  PC_WIDTH  address of the word currently on imem_q (valid in RUN)
- issued  out  COUNT_WIDTH  non-NOP-injected instructions issued since last start

## Operation
- States: IDLE, FETCH, RUN, HOLD.
- IDLE: `instruction`=NOP; `host_gnt`<=`host_req`. If `start` is high and `host_gnt`=0, then `pc`<=`start_pc`, `issued`<=0, and the state goes to FETCH. While `host_gnt`=1, `start` is ignored.
- FETCH: `imem_addr`=`pc`, `instruction`=NOP. Next state is RUN, with `imem_addr`<=`pc`+1.
- RUN: each edge, `imem_q` holds mem[`pc`]. Priority order:
  - `abort`: go to IDLE, NOP.
  - `host_req`: do not issue the word; `instruction`<=NOP, `host_gnt`<=1, keep `pc`, go to HOLD.
  - `imem_q`==HALT: `instruction`<=NOP, `done`<=1, go to IDLE.
  - Otherwise: `instruction`<=`imem_q`, `issued`+=1, `pc`+=1, `imem_addr`<=`pc`+2.
- HOLD: `instruction`=NOP, `host_gnt`=1. When `host_req` is sampled low, `host_gnt`<=0 and the state goes to FETCH, which refetches `pc`. `abort` goes to IDLE.
- `pc` and `imem_addr` wrap modulo 2^PC_WIDTH with no error. `issued` saturates at all-ones.
- A word equal to NOP in memory is issued and counted like any other instruction.

## Timing
- Reset (async assert, sync release): state IDLE; `instruction`=NOP; `busy`, `done`, `host_gnt` = 0; `imem_addr`, `pc`, `issued` = 0.
- `start` sampled at edge k: mem[`start_pc`] appears on `instruction` after edge k+2. After that, throughput is 1 instruction/cycle.
- `host_req` sampled high at edge k in RUN: `host_gnt`=1 and `instruction`=NOP after edge k. This costs one unissued word, which is refetched.
- `host_req` sampled low at edge j in HOLD: `host_gnt`=0 after j. The resumed word appears on `instruction` after j+2.
- HALT reaches `imem_q` at edge k: `done`=1 for cycle k..k+1, and `busy`=0 after k.
- `abort` and `host_req` together: `abort` wins and `host_gnt` stays 0.
- `host_req` and HALT together: `host_req` wins and HALT is refetched after the hold.
- `start` outside IDLE has no effect.
- Reset mid-RUN: all outputs return to reset values immediately; SM sees NOP.

## Structure
- Shared package `sm_pkg` holds INSTRUCTION_WIDTH, the NOP and HALT encodings, and the state enum. SM and the testbench import the same constants.
- Single module, no sub-module. The instruction RAM is external (OnePortRAM-style, registered output).

## Test plan
- Program {0x0280 (movl r0,0), 0x0090, 0x0AA4, HALT} at 0x10, start_pc=0x10:
  - `instruction` = 0x0280, 0x0090, 0x0AA4 on consecutive cycles starting 2 cycles after `start`.
  - `done` pulses once; `issued`=3; `busy` drops.
- `host_req` raised for 4 cycles during the second instruction of a 6-word program:
  - NOP during hold; `host_gnt` high for exactly the hold.
  - All 6 words issued in order with no duplicate or skip; `issued`=6.
- `host_req` in the same cycle HALT is on `imem_q`: hold taken first. After release, HALT is refetched, `done` pulses, and `issued` is unchanged.
- `abort` mid-RUN: NOP next cycle, no `done`, state IDLE. A following `start` runs normally.
- start_pc=0xFE with words at 0xFE, 0xFF, 0x00, then HALT at 0x01: `pc` wraps to 0x00 and 3 instructions are issued.
- `rst_n` asserted mid-RUN and mid-HOLD: outputs go to reset values without a clock edge. `start` in IDLE while `host_gnt`=1 is ignored.
